// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan and bit-plane scheduler: streams framebuffer row pairs into the panel
// shift chain and time-slices OE with binary-coded modulation.
module hub75_scan_ctrl #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 4,
    parameter int PLANES   = 4,
    parameter int BASE_ON  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    output logic [ROW_BITS+$clog2(COLS)-1:0]  rd_addr,
    input  logic [6*PLANES-1:0]               rd_data,
    output logic                              A,
    output logic                              B,
    output logic                              C,
    output logic                              D,
    output logic                              R0,
    output logic                              G0,
    output logic                              B0,
    output logic                              R1,
    output logic                              G1,
    output logic                              B1,
    output logic                              clk_shft,
    output logic                              LAT,
    output logic                              OE,
    output logic                              frame_done,
    output logic                              busy
);

    localparam int CB = $clog2(COLS);
    localparam int PB = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int DW = $clog2(BASE_ON << (PLANES - 1)) + 1;
    localparam int AW = ROW_BITS + CB;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        BLANK   = 3'd2,
        LATCH   = 3'd3,
        DISPLAY = 3'd4
    } state_t;

    state_t                state_r, state_nxt_s;
    logic                  phase_r, phase_nxt_s;
    logic [CB-1:0]         col_r, col_nxt_s;
    logic [ROW_BITS-1:0]   row_r, row_nxt_s;
    logic [PB-1:0]         plane_r, plane_nxt_s;
    logic [DW-1:0]         cnt_r, cnt_nxt_s;
    logic [AW-1:0]         rd_addr_r, rd_addr_nxt_s;
    logic [5:0]            rgb_r, rgb_nxt_s;
    logic [ROW_BITS-1:0]   abcd_r, abcd_nxt_s;
    logic                  clk_shft_r, clk_shft_nxt_s;
    logic                  lat_r, lat_nxt_s;
    logic                  oe_r, oe_nxt_s;
    logic                  frame_done_r, frame_done_nxt_s;
    logic                  busy_r, busy_nxt_s;

    logic [DW-1:0]         on_len_s;
    logic                  disp_last_s;
    logic                  row_adv_s;
    logic [ROW_BITS-1:0]   next_row_s;
    logic [PB-1:0]         next_plane_s;
    logic [3:0]            pins_s;

    // Picks bit p of each colour field; field 5 is R0, field 0 is B1.
    function automatic logic [5:0] plane_bits(input logic [6*PLANES-1:0] word,
                                              input logic [PB-1:0] p);
        logic [5:0] bits;
        for (int f = 0; f < 6; f++) begin
            bits[f] = word[f*PLANES + int'(p)];
        end
        return bits;
    endfunction

    assign on_len_s     = DW'(BASE_ON) << plane_r;
    assign disp_last_s  = (cnt_r == (on_len_s - DW'(1)));
    assign row_adv_s    = (plane_r == PB'(PLANES - 1));
    assign next_row_s   = row_adv_s ? (row_r + ROW_BITS'(1)) : row_r;
    assign next_plane_s = row_adv_s ? PB'(0) : (plane_r + PB'(1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, counters and next panel outputs; panel pins lag the state by one cycle
    always_comb begin
        state_nxt_s      = state_r;
        phase_nxt_s      = phase_r;
        col_nxt_s        = col_r;
        row_nxt_s        = row_r;
        plane_nxt_s      = plane_r;
        cnt_nxt_s        = cnt_r;
        rd_addr_nxt_s    = rd_addr_r;
        rgb_nxt_s        = rgb_r;
        abcd_nxt_s       = abcd_r;
        clk_shft_nxt_s   = 1'b0;
        lat_nxt_s        = 1'b0;
        oe_nxt_s         = 1'b1;
        frame_done_nxt_s = 1'b0;
        busy_nxt_s       = (state_r != IDLE);
        case (state_r)
            IDLE: begin
                rgb_nxt_s = 6'd0;
                if (en) begin
                    state_nxt_s = SHIFT;
                    phase_nxt_s = 1'b0;
                    col_nxt_s   = CB'(0);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (!phase_r) begin
                    rgb_nxt_s     = plane_bits(rd_data, plane_r);
                    phase_nxt_s   = 1'b1;
                    rd_addr_nxt_s = {row_r, col_r + CB'(1)};
                end else begin
                    clk_shft_nxt_s = 1'b1;
                    phase_nxt_s    = 1'b0;
                    col_nxt_s      = col_r + CB'(1);
                    if (col_r == CB'(COLS - 1)) begin
                        state_nxt_s = BLANK;
                    end else begin
                        state_nxt_s = SHIFT;
                    end
                end
            end
            BLANK: begin
                state_nxt_s = LATCH;
                cnt_nxt_s   = DW'(0);
            end
            LATCH: begin
                lat_nxt_s     = 1'b1;
                abcd_nxt_s    = row_r;
                rd_addr_nxt_s = {next_row_s, CB'(0)};
                cnt_nxt_s     = DW'(0);
                state_nxt_s   = DISPLAY;
            end
            DISPLAY: begin
                oe_nxt_s = 1'b0;
                if (disp_last_s) begin
                    frame_done_nxt_s = row_adv_s && (row_r == {ROW_BITS{1'b1}});
                    if (en) begin
                        state_nxt_s = SHIFT;
                        phase_nxt_s = 1'b0;
                        col_nxt_s   = CB'(0);
                        row_nxt_s   = next_row_s;
                        plane_nxt_s = next_plane_s;
                    end else begin
                        state_nxt_s   = IDLE;
                        row_nxt_s     = ROW_BITS'(0);
                        plane_nxt_s   = PB'(0);
                        rd_addr_nxt_s = AW'(0);
                    end
                end else begin
                    cnt_nxt_s = cnt_r + DW'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Datapath and registered panel outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r      <= 1'b0;
            col_r        <= CB'(0);
            row_r        <= ROW_BITS'(0);
            plane_r      <= PB'(0);
            cnt_r        <= DW'(0);
            rd_addr_r    <= AW'(0);
            rgb_r        <= 6'd0;
            abcd_r       <= ROW_BITS'(0);
            clk_shft_r   <= 1'b0;
            lat_r        <= 1'b0;
            oe_r         <= 1'b1;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            phase_r      <= phase_nxt_s;
            col_r        <= col_nxt_s;
            row_r        <= row_nxt_s;
            plane_r      <= plane_nxt_s;
            cnt_r        <= cnt_nxt_s;
            rd_addr_r    <= rd_addr_nxt_s;
            rgb_r        <= rgb_nxt_s;
            abcd_r       <= abcd_nxt_s;
            clk_shft_r   <= clk_shft_nxt_s;
            lat_r        <= lat_nxt_s;
            oe_r         <= oe_nxt_s;
            frame_done_r <= frame_done_nxt_s;
            busy_r       <= busy_nxt_s;
        end
    end

    assign pins_s     = 4'(abcd_r);
    assign A          = pins_s[0];
    assign B          = pins_s[1];
    assign C          = pins_s[2];
    assign D          = pins_s[3];
    assign R0         = rgb_r[5];
    assign G0         = rgb_r[4];
    assign B0         = rgb_r[3];
    assign R1         = rgb_r[2];
    assign G1         = rgb_r[1];
    assign B1         = rgb_r[0];
    assign rd_addr    = rd_addr_r;
    assign clk_shft   = clk_shft_r;
    assign LAT        = lat_r;
    assign OE         = oe_r;
    assign frame_done = frame_done_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Self-checking bench for hub75_scan_ctrl: a synchronous framebuffer model feeds the
// DUT and a pin-level monitor compares the panel waveform with the scan rules.
module tb_hub75_scan_ctrl;

    localparam int COLS    = 64;
    localparam int PLANES  = 4;
    localparam int BASE_ON = 8;
    localparam int FRAME   = 10240;

    logic        clk, rst, en;
    logic [9:0]  rd_addr;
    logic [23:0] rd_data;
    logic        A, B, C, D, R0, G0, B0, R1, G1, B1;
    logic        clk_shft, LAT, OE, frame_done, busy;

    logic [23:0] fb [0:1023];
    logic [5:0]  rgb_obs;
    logic [3:0]  abcd_obs;

    int          n_checks = 0;
    int          n_errors = 0;

    // scan model state, owned by the monitor
    logic [3:0]  exp_row;
    int          exp_plane;
    int          shift_cnt;
    int          oe_low;
    int          lat_frame;
    int          cyc = 0;
    int          last_fd;
    bit          fd_valid;
    logic        prev_shft, prev_lat, prev_oe, prev_fd;
    logic [3:0]  prev_abcd;

    assign rgb_obs  = {R0, G0, B0, R1, G1, B1};
    assign abcd_obs = {D, C, B, A};

    hub75_scan_ctrl #(.COLS(COLS), .ROW_BITS(4), .PLANES(PLANES), .BASE_ON(BASE_ON)) dut (
        .clk(clk), .rst(rst), .en(en), .rd_addr(rd_addr), .rd_data(rd_data),
        .A(A), .B(B), .C(C), .D(D),
        .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
        .clk_shft(clk_shft), .LAT(LAT), .OE(OE), .frame_done(frame_done), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) rd_data <= fb[rd_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] exp_rgb(input logic [3:0] row, input int plane, input int col);
        logic [23:0] w;
        logic [9:0]  a;
        a = {row, 6'(col)};
        w = fb[a];
        return {w[20+plane], w[16+plane], w[12+plane], w[8+plane], w[4+plane], w[plane]};
    endfunction

    // Pin monitor: every shift edge, latch, display window and frame pulse is compared
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_row = 4'd0; exp_plane = 0; shift_cnt = 0; oe_low = 0;
                lat_frame = 0; fd_valid = 1'b0; last_fd = 0;
            end else begin
                if (clk_shft && !prev_shft) begin
                    if (shift_cnt < COLS) chk("shift_rgb", rgb_obs, exp_rgb(exp_row, exp_plane, shift_cnt));
                    shift_cnt++;
                end
                if (prev_lat) chk("lat_width", LAT, 1'b0);
                if (LAT && !prev_lat) begin
                    chk("lat_shifts", shift_cnt, COLS);
                    chk("lat_row", abcd_obs, exp_row);
                    chk("lat_oe", OE, 1'b1);
                    shift_cnt = 0;
                    lat_frame++;
                end
                if (abcd_obs != prev_abcd) chk("abcd_oe", OE, 1'b1);
                if (!OE) oe_low++;
                if (OE && !prev_oe) begin
                    chk("oe_len", oe_low, BASE_ON << exp_plane);
                    oe_low = 0;
                    if (!en) begin
                        exp_row = 4'd0; exp_plane = 0; lat_frame = 0; fd_valid = 1'b0;
                    end else if (exp_plane == PLANES - 1) begin
                        exp_plane = 0;
                        exp_row   = exp_row + 4'd1;
                    end else begin
                        exp_plane++;
                    end
                end
                if (prev_fd) chk("fd_width", frame_done, 1'b0);
                if (frame_done) begin
                    chk("fd_pos", {exp_row, 8'(exp_plane)}, {4'd15, 8'd3});
                    chk("fd_lats", lat_frame, 16 * PLANES);
                    if (fd_valid) chk("fd_period", cyc - last_fd, FRAME);
                    fd_valid  = 1'b1;
                    last_fd   = cyc;
                    lat_frame = 0;
                end
            end
            prev_shft = clk_shft; prev_lat = LAT; prev_oe = OE;
            prev_fd = frame_done; prev_abcd = abcd_obs;
        end
    end

    task automatic wait_idle(input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (!busy) hit = 1'b1;
        end
        chk(tag, hit, 1'b1);
        @(negedge clk);
        chk("idle_oe", OE, 1'b1);
        chk("idle_busy", busy, 1'b0);
        chk("idle_shft", clk_shft, 1'b0);
    endtask

    // Drops en in the middle of a shift of the requested row/plane (-1 = any)
    task automatic drop_en_at(input int row, input int plane, input int limit);
        bit hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clk);
            if (shift_cnt >= 2 && shift_cnt <= COLS - 4 &&
                (row < 0 || int'(exp_row) == row) && (plane < 0 || exp_plane == plane)) hit = 1'b1;
        end
        chk("drop_wait", hit, 1'b1);
        en = 1'b0;
        wait_idle("drop_idle");
    endtask

    task automatic run_until_row(input int row, input int limit);
        bit hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clk);
            if (int'(exp_row) == row) hit = 1'b1;
        end
        chk("row_reached", hit, 1'b1);
    endtask

    initial begin
        bit hit;
        int fdn;
        rst = 1'b1;
        en  = 1'b0;
        for (int i = 0; i < 1024; i++) fb[i] = 24'hFFFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_oe", OE, 1'b1);
        chk("rst_abcd", abcd_obs, 4'd0);
        chk("rst_rgb", rgb_obs, 6'd0);
        chk("rst_shft", clk_shft, 1'b0);
        chk("rst_lat", LAT, 1'b0);
        chk("rst_fd", frame_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr", rd_addr, 10'd0);

        // all-white frame: every edge carries all ones, OE windows 8/16/32/64
        en = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < FRAME + 400 && !hit; i++) begin
            @(negedge clk);
            if (frame_done) hit = 1'b1;
        end
        chk("white_frame", hit, 1'b1);
        drop_en_at(-1, -1, 800);

        // single red pixel at row 0 col 5, value 4'b1010
        for (int i = 0; i < 1024; i++) fb[i] = 24'h000000;
        fb[5] = 24'hA00000;
        en = 1'b1;
        run_until_row(1, 900);
        drop_en_at(-1, -1, 800);

        // random framebuffer, two full frames to see the frame period
        for (int i = 0; i < 1024; i++) fb[i] = 24'($urandom);
        en = 1'b1;
        fdn = 0;
        for (int i = 0; i < 2 * FRAME + 400 && fdn < 2; i++) begin
            @(negedge clk);
            if (frame_done) fdn++;
        end
        chk("fd_twice", fdn, 2);

        // en dropped during row 3 plane 2 shift: plane completes, then idle
        drop_en_at(3, 2, 4000);
        repeat (5) @(negedge clk);
        chk("hold_busy", busy, 1'b0);
        chk("hold_oe", OE, 1'b1);
        en = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            if (LAT) hit = 1'b1;
        end
        chk("restart_lat", hit, 1'b1);
        chk("restart_row", abcd_obs, 4'd0);

        // asynchronous reset in the middle of a display window
        run_until_row(2, 1500);
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (!OE) hit = 1'b1;
        end
        chk("disp_wait", hit, 1'b1);
        #1 rst = 1'b1;
        en = 1'b0;
        #1;
        chk("arst_oe", OE, 1'b1);
        chk("arst_abcd", abcd_obs, 4'd0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_lat", LAT, 1'b0);
        chk("arst_addr", rd_addr, 10'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_oe", OE, 1'b1);
        chk("post_rgb", rgb_obs, 6'd0);
        chk("post_busy", busy, 1'b0);
        chk("post_shft", clk_shft, 1'b0);
        en = 1'b1;
        run_until_row(1, 900);
        en = 1'b0;
        repeat (300) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
